fifo_param: RTL and testbench
=============================

Name: fifo_param

Overview:
Parametrised successor to the team's 4-bit synchronous FIFO. Data width and depth are generic. Almost-full and almost-empty thresholds are runtime-programmable. The block adds a registered read-valid strobe and sticky overflow/underflow error flags with a clear input. It sits between the same producers and consumers as the current FIFO and reuses its flag and counter port names.

Parameters:
DATA_WIDTH, 4, width of each stored word.
BUF_WIDTH, 3, log2 of depth; depth = 2^BUF_WIDTH entries.

Ports:
clk  input  1  clock; all state updates on rising edge.
rst  input  1  reset; synchronous, active-low (rst=0 at a rising edge of clk resets the block).
wr_en  input  1  push request.
rd_en  input  1  pop request.
buf_in  input  DATA_WIDTH  write data.
af_thresh  input  BUF_WIDTH+1  almost-full threshold.
ae_thresh  input  BUF_WIDTH+1  almost-empty threshold.
err_clr  input  1  clears overflow/underflow.
buf_out  output  DATA_WIDTH  registered read data.
out_valid  output  1  buf_out updated by a pop on the last edge.
buf_full  output  1  fifo_counter == 2^BUF_WIDTH.
buf_empty  output  1  fifo_counter == 0.
almost_full  output  1  fifo_counter >= af_thresh.
almost_empty  output  1  fifo_counter <= ae_thresh.
fifo_counter  output  BUF_WIDTH+1  occupancy, 0..2^BUF_WIDTH.
overflow  output  1  sticky: push attempted while full and not popped.
underflow  output  1  sticky: pop attempted while empty.

Behaviour:
- Reset (rst=0 at an edge):
  - rd_ptr, wr_ptr, fifo_counter, buf_out, out_valid, overflow and underflow all go to 0.
  - Memory contents are not cleared.
  - Reset has priority over every other input, including mid-operation; no push or pop is committed on that edge.
- Pointers are BUF_WIDTH bits and wrap naturally from 2^BUF_WIDTH-1 to 0.
- Accept rules, evaluated on registered state before the edge:
  - push_ok = wr_en & (!buf_full | rd_en).
  - pop_ok = rd_en & !buf_empty.
- Push: mem[wr_ptr] <= buf_in; wr_ptr+1.
- Pop: buf_out <= mem[rd_ptr]; rd_ptr+1; out_valid=1 for the following cycle only. Read latency is one edge, matching the existing pop timing: data is valid 1 ns after the edge that sampled rd_en.
- With no pop, out_valid=0 and buf_out holds its last value.
- Simultaneous wr_en & rd_en:
  - When full: both are accepted; counter stays at 2^BUF_WIDTH; the oldest word is read and the new word is written into the freed slot.
  - When empty: the push is accepted, the pop is rejected (no fall-through), underflow is set, and the counter goes to 1.
  - Otherwise: both are accepted and the counter is unchanged.
- Counter update: fifo_counter += push_ok - pop_ok. It never exceeds 2^BUF_WIDTH and never goes below 0.
- Flags:
  - buf_full, buf_empty, almost_full and almost_empty are combinational from fifo_counter and the threshold inputs. They are valid in the same cycle the counter updates.
  - Threshold changes take effect immediately.
  - af_thresh=0 forces almost_full=1.
  - ae_thresh >= depth forces almost_empty=1.
- Errors:
  - overflow <= 1 on wr_en & buf_full & !rd_en.
  - underflow <= 1 on rd_en & buf_empty.
  - Rejected operations leave pointers, counter and buf_out unchanged.
  - err_clr=1 clears both flags at the edge. If an error event coincides with err_clr, set wins.
- No combinational path from wr_en or rd_en to any output.
- Expected RTL is a ~160-250 line single module. Memory is an inferred register array. Counter and flags must synthesise cleanly with the current flow.

Test Plan:
(Defaults DATA_WIDTH=4, BUF_WIDTH=3, af_thresh=6, ae_thresh=1.)
1. Reset: hold rst=0 for 2 edges with wr_en=1 -> fifo_counter=0, buf_empty=1, almost_empty=1, out_valid=0, buf_out=0. Release, push 1, pop -> buf_out=1, out_valid=1 for exactly one cycle.
2. Fill/overflow: push 1..8 -> counter 6 asserts almost_full, counter 8 asserts buf_full. Push 9 alone -> overflow=1, counter stays 8. Pop 8 times -> outputs 1..8 in order, then buf_empty=1.
3. Full simultaneous: fill with 1..8, then wr_en=rd_en=1 with buf_in=12 -> buf_out=1, counter stays 8, no overflow. Drain -> 2..8,12.
4. Empty simultaneous: from empty, wr_en=rd_en=1 with buf_in=5 -> counter=1, underflow=1, out_valid=0. Next pop -> buf_out=5.
5. Wrap and thresholds: push/pop 20 words cycling through all pointer positions with occupancy held at 3 -> data order preserved. Set af_thresh=3 mid-stream -> almost_full rises in the same cycle. err_clr=1 -> overflow=underflow=0 on the next edge.
6. Reset mid-operation: with counter=5, assert rst=0 together with wr_en=1 -> counter=0 and all flags at reset values. The subsequent pop is rejected and sets underflow.

Source files
------------

// File: rtl/fifo_if.sv
// Handshake and status bundle for fifo_param. The master side is the producer/consumer
// pair. The slave side is the FIFO itself.
interface fifo_if #(
   parameter int DATA_WIDTH = 4,
   parameter int BUF_WIDTH  = 3
);
   logic                  wr_en;
   logic                  rd_en;
   logic [DATA_WIDTH-1:0] buf_in;
   logic [BUF_WIDTH:0]    af_thresh;
   logic [BUF_WIDTH:0]    ae_thresh;
   logic                  err_clr;
   logic [DATA_WIDTH-1:0] buf_out;
   logic                  out_valid;
   logic                  buf_full;
   logic                  buf_empty;
   logic                  almost_full;
   logic                  almost_empty;
   logic [BUF_WIDTH:0]    fifo_counter;
   logic                  overflow;
   logic                  underflow;

   modport master (
      output wr_en, rd_en, buf_in, af_thresh, ae_thresh, err_clr,
      input  buf_out, out_valid, buf_full, buf_empty, almost_full, almost_empty,
             fifo_counter, overflow, underflow
   );

   modport slave (
      input  wr_en, rd_en, buf_in, af_thresh, ae_thresh, err_clr,
      output buf_out, out_valid, buf_full, buf_empty, almost_full, almost_empty,
             fifo_counter, overflow, underflow
   );
endinterface

// File: rtl/fifo_param.sv
// Parametrised synchronous FIFO with registered read data, programmable almost
// thresholds and sticky overflow/underflow flags.
module fifo_param #(
   parameter int DATA_WIDTH = 4,
   parameter int BUF_WIDTH  = 3
) (
   input logic  clk,
   input logic  rst,
   fifo_if.slave bus
);
   localparam int                 DEPTH     = 1 << BUF_WIDTH;
   localparam logic [BUF_WIDTH:0] DEPTH_CNT = (BUF_WIDTH+1)'(DEPTH);

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [BUF_WIDTH-1:0]  wr_ptr;
   logic [BUF_WIDTH-1:0]  rd_ptr;
   logic [BUF_WIDTH:0]    count;
   logic [DATA_WIDTH-1:0] rd_data;
   logic                  rd_vld;
   logic                  ovf_flag;
   logic                  unf_flag;
   logic                  full;
   logic                  empty;
   logic                  push_ok;
   logic                  pop_ok;
   logic                  ovf_evt;
   logic                  unf_evt;

   // Occupancy moves by at most one; a simultaneous accepted push and pop cancel out.
   function automatic logic [BUF_WIDTH:0] next_count(
      input logic [BUF_WIDTH:0] cnt,
      input logic               push,
      input logic               pop
   );
      logic [BUF_WIDTH:0] res;
      res = cnt;
      if (push && !pop)
         res = cnt + 1'b1;
      else if (pop && !push)
         res = cnt - 1'b1;
      return res;
   endfunction

   assign full    = (count == DEPTH_CNT);
   assign empty   = (count == '0);
   assign push_ok = bus.wr_en & (~full | bus.rd_en);
   assign pop_ok  = bus.rd_en & ~empty;
   assign ovf_evt = bus.wr_en & full & ~bus.rd_en;
   assign unf_evt = bus.rd_en & empty;

   // Storage is not reset; a reset edge commits no write.
   always_ff @(posedge clk) begin
      if (rst && push_ok)
         mem[wr_ptr] <= bus.buf_in;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         rd_data  <= '0;
         rd_vld   <= 1'b0;
         ovf_flag <= 1'b0;
         unf_flag <= 1'b0;
      end else begin
         if (push_ok)
            wr_ptr <= wr_ptr + 1'b1;
         if (pop_ok) begin
            rd_ptr  <= rd_ptr + 1'b1;
            rd_data <= mem[rd_ptr];
         end
         rd_vld   <= pop_ok;
         count    <= next_count(count, push_ok, pop_ok);
         // A new error event outranks a clear on the same edge.
         ovf_flag <= ovf_evt | (ovf_flag & ~bus.err_clr);
         unf_flag <= unf_evt | (unf_flag & ~bus.err_clr);
      end
   end

   assign bus.buf_out      = rd_data;
   assign bus.out_valid    = rd_vld;
   assign bus.fifo_counter = count;
   assign bus.buf_full     = full;
   assign bus.buf_empty    = empty;
   assign bus.almost_full  = (count >= bus.af_thresh);
   assign bus.almost_empty = (count <= bus.ae_thresh);
   assign bus.overflow     = ovf_flag;
   assign bus.underflow    = unf_flag;
endmodule

// File: tb/tb_fifo_param.sv
// Directed bench for fifo_param: a scoreboard queue feeds a negedge monitor of popped data.
module tb_fifo_param;
   logic clk;
   logic rst;
   int   tests;
   int   fails;
   logic [3:0] exp_q [$];

   fifo_if #(.DATA_WIDTH(4), .BUF_WIDTH(3)) bus ();

   fifo_param #(.DATA_WIDTH(4), .BUF_WIDTH(3)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d", name, act, req);
      end
   endtask

   // Monitor: every out_valid cycle consumes one expected word.
   always @(negedge clk) begin
      if (bus.out_valid === 1'b1) begin
         if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_pop: got %0d, expected no output", bus.buf_out);
         end else begin
            check("pop_data", 32'(bus.buf_out), 32'(exp_q.pop_front()));
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [3:0] d);
      bus.wr_en = 1'b1; bus.rd_en = 1'b0; bus.buf_in = d;
      step();
      bus.wr_en = 1'b0;
   endtask

   task automatic pop_exp(input logic [3:0] d);
      bus.wr_en = 1'b0; bus.rd_en = 1'b1;
      exp_q.push_back(d);
      step();
      bus.rd_en = 1'b0;
   endtask

   task automatic both_exp(input logic [3:0] din, input logic [3:0] dout);
      bus.wr_en = 1'b1; bus.rd_en = 1'b1; bus.buf_in = din;
      exp_q.push_back(dout);
      step();
      bus.wr_en = 1'b0; bus.rd_en = 1'b0;
   endtask

   initial begin
      tests = 0;
      fails = 0;
      rst = 1'b0;
      bus.wr_en = 1'b1; bus.rd_en = 1'b0; bus.buf_in = 4'd7;
      bus.af_thresh = 4'd6; bus.ae_thresh = 4'd1; bus.err_clr = 1'b0;

      // 1. reset with a push held high
      step(); step();
      check("rst_counter", 32'(bus.fifo_counter), 0);
      check("rst_empty", 32'(bus.buf_empty), 1);
      check("rst_almost_empty", 32'(bus.almost_empty), 1);
      check("rst_out_valid", 32'(bus.out_valid), 0);
      check("rst_buf_out", 32'(bus.buf_out), 0);
      check("rst_overflow", 32'(bus.overflow), 0);
      check("rst_underflow", 32'(bus.underflow), 0);
      rst = 1'b1; bus.wr_en = 1'b0;
      push(4'd1);
      check("t1_count", 32'(bus.fifo_counter), 1);
      pop_exp(4'd1);
      check("t1_valid_hi", 32'(bus.out_valid), 1);
      step();
      check("t1_valid_lo", 32'(bus.out_valid), 0);

      // 2. fill, overflow, drain
      for (int i = 1; i <= 8; i++) begin
         push(4'(i));
         check("t2_count", 32'(bus.fifo_counter), 32'(i));
         check("t2_almost_full", 32'(bus.almost_full), 32'(i >= 6));
         check("t2_full", 32'(bus.buf_full), 32'(i == 8));
         check("t2_almost_empty", 32'(bus.almost_empty), 32'(i <= 1));
      end
      push(4'd9);
      check("t2_overflow", 32'(bus.overflow), 1);
      check("t2_count_hold", 32'(bus.fifo_counter), 8);
      for (int i = 1; i <= 8; i++) pop_exp(4'(i));
      check("t2_empty", 32'(bus.buf_empty), 1);
      bus.err_clr = 1'b1;
      step();
      bus.err_clr = 1'b0;
      check("t2_ovf_clr", 32'(bus.overflow), 0);

      // 3. simultaneous push/pop while full
      for (int i = 1; i <= 8; i++) push(4'(i));
      both_exp(4'd12, 4'd1);
      check("t3_count", 32'(bus.fifo_counter), 8);
      check("t3_no_ovf", 32'(bus.overflow), 0);
      for (int i = 2; i <= 8; i++) pop_exp(4'(i));
      pop_exp(4'd12);
      check("t3_empty", 32'(bus.buf_empty), 1);

      // 4. simultaneous push/pop while empty: no fall-through
      bus.wr_en = 1'b1; bus.rd_en = 1'b1; bus.buf_in = 4'd5;
      step();
      bus.wr_en = 1'b0; bus.rd_en = 1'b0;
      check("t4_count", 32'(bus.fifo_counter), 1);
      check("t4_underflow", 32'(bus.underflow), 1);
      check("t4_out_valid", 32'(bus.out_valid), 0);
      pop_exp(4'd5);
      check("t4_count0", 32'(bus.fifo_counter), 0);

      // 5. streaming at occupancy 3 across every pointer position
      push(4'd0); push(4'd3); push(4'd6);
      check("t5_af_lo", 32'(bus.almost_full), 0);
      for (int k = 0; k < 20; k++) begin
         if (k == 10) begin
            bus.af_thresh = 4'd3;
            #1;
            check("t5_af_immediate", 32'(bus.almost_full), 1);
         end
         both_exp(4'(3 * (k + 3)), 4'(3 * k));
         check("t5_count", 32'(bus.fifo_counter), 3);
      end
      pop_exp(4'(3 * 20)); pop_exp(4'(3 * 21)); pop_exp(4'(3 * 22));
      bus.af_thresh = 4'd6;
      for (int i = 0; i < 8; i++) push(4'(i + 8));
      bus.ae_thresh = 4'd8;
      #1;
      check("t5_ae_at_depth", 32'(bus.almost_empty), 1);
      bus.ae_thresh = 4'd1;
      push(4'd0);
      check("t5_overflow", 32'(bus.overflow), 1);
      bus.err_clr = 1'b1;
      step();
      check("t5_ovf_clr", 32'(bus.overflow), 0);
      check("t5_unf_clr", 32'(bus.underflow), 0);
      bus.wr_en = 1'b1; bus.buf_in = 4'd1;
      step();
      bus.wr_en = 1'b0; bus.err_clr = 1'b0;
      check("t5_set_wins", 32'(bus.overflow), 1);

      // 6. reset in the middle of traffic
      pop_exp(4'd8); pop_exp(4'd9); pop_exp(4'd10);
      check("t6_count5", 32'(bus.fifo_counter), 5);
      rst = 1'b0; bus.wr_en = 1'b1; bus.buf_in = 4'd3;
      step();
      rst = 1'b1; bus.wr_en = 1'b0;
      check("t6_count", 32'(bus.fifo_counter), 0);
      check("t6_empty", 32'(bus.buf_empty), 1);
      check("t6_overflow", 32'(bus.overflow), 0);
      check("t6_out_valid", 32'(bus.out_valid), 0);
      check("t6_buf_out", 32'(bus.buf_out), 0);
      bus.af_thresh = 4'd0;
      #1;
      check("t6_af_zero", 32'(bus.almost_full), 1);
      bus.af_thresh = 4'd6;
      bus.rd_en = 1'b1;
      step();
      bus.rd_en = 1'b0;
      check("t6_underflow", 32'(bus.underflow), 1);
      check("t6_pop_rejected", 32'(bus.out_valid), 0);
      check("t6_count_after", 32'(bus.fifo_counter), 0);

      step(); step();
      check("sb_drained", 32'(exp_q.size()), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
